// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory port: size codes, write-enable level, responder FSM states.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package cpu_mem_pkg;

  // Access size codes carried on req_size
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HWORD   = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Write enable is neg-asserted: 0 means store, 1 means load
  localparam logic WEN_STORE = 1'b0;
  localparam logic WEN_LOAD  = 1'b1;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte-lane write strobes for an access of the given size at byte offset off
  function automatic logic [3:0] size_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE:  return 4'b0001 << off;
      SIZE_HWORD: return 4'b0011 << off;
      SIZE_WORD:  return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  // True when the offset is not a multiple of the access size
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_HWORD: return off[0];
      SIZE_WORD:  return off != 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it could land in,
  // so the strobes alone decide which bytes are written
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE:  return {4{wdata[7:0]}};
      SIZE_HWORD: return {2{wdata[15:0]}};
      default:    return wdata;
    endcase
  endfunction

  // Select the addressed lane from a word and zero-extend it, right-justified
  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE:  return {24'h0, sh[7:0]};
      SIZE_HWORD: return {16'h0, sh[15:0]};
      default:    return sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write strobes; contents are never reset.
// Latency: write takes effect at the clock edge, read is combinational from the index.
// Backpressure: none, a write is performed whenever any strobe is set.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_idx,
  input  logic [3:0]    i_we_strb,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-granular write: only strobed lanes change, the rest keep their value
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we_strb[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one byte/halfword/word load or store at a time against a little-endian array.
// Latency: access performed and response valid LATENCY cycles after request acceptance (1..15).
// Backpressure: response held until resp_ready; no new request accepted until the response handshakes.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int         AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
  // With a single cycle of latency the access happens on the accepting edge,
  // so it has to use the live request bus instead of the captured copy
  localparam bit          DIRECT     = (LATENCY == 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_wen;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_do_access;

  logic [31:0] w_acc_addr;
  logic [1:0]  w_acc_size;
  logic        w_acc_wen;
  logic [31:0] w_acc_wdata;
  logic        w_acc_err;
  logic        w_acc_store;
  logic [3:0]  w_we_strb;
  logic [31:0] w_wdata_lanes;
  logic [31:0] w_word;
  logic [AW-1:0] w_idx;
  logic        w_unused_addr_hi;

  // State and latency counter; synchronous reset wins over everything
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and handshake outputs; ready/valid depend on state only
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    w_accept     = 1'b0;
    w_do_access  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = CNT_LOAD;
          if (DIRECT) begin
            w_do_access = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A counter of 0 cannot occur here, but treat it as expiry rather than wrapping
        if (r_cnt <= 4'd1) begin
          w_do_access = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Operands of the access: live bus on the accepting edge when LATENCY is 1, captured copy otherwise
  assign w_acc_addr  = (DIRECT && (r_state == ST_IDLE)) ? i_req_addr  : r_addr;
  assign w_acc_size  = (DIRECT && (r_state == ST_IDLE)) ? i_req_size  : r_size;
  assign w_acc_wen   = (DIRECT && (r_state == ST_IDLE)) ? i_req_wen   : r_wen;
  assign w_acc_wdata = (DIRECT && (r_state == ST_IDLE)) ? i_req_wdata : r_wdata;

  // Any error suppresses the array write and forces zero read data
  assign w_acc_err = (w_acc_size == SIZE_ILLEGAL)
                   | misaligned(w_acc_size, w_acc_addr[1:0])
                   | ({1'b0, w_acc_addr} >= ADDR_LIMIT);

  assign w_acc_store   = (w_acc_wen == WEN_STORE);
  assign w_idx         = w_acc_addr[AW+1:2];
  assign w_wdata_lanes = lane_replicate(w_acc_size, w_acc_wdata);
  assign w_we_strb     = (w_do_access && !w_acc_err && w_acc_store)
                       ? size_strobe(w_acc_size, w_acc_addr[1:0]) : 4'b0000;

  // Upper address bits only matter for the range check above
  assign w_unused_addr_hi = ^w_acc_addr[31:AW+2];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk     (i_clk),
    .i_idx     (w_idx),
    .i_we_strb (w_we_strb),
    .i_wdata   (w_wdata_lanes),
    .o_rdata   (w_word)
  );

  // Capture the request on acceptance and latch the response on the access edge
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_addr  <= 32'h0;
      r_size  <= SIZE_BYTE;
      r_wen   <= WEN_LOAD;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_size  <= i_req_size;
        r_wen   <= i_req_wen;
        r_wdata <= i_req_wdata;
      end
      if (w_do_access) begin
        r_err   <= w_acc_err;
        r_rdata <= (w_acc_err || w_acc_store) ? 32'h0
                 : lane_extract(w_acc_size, w_acc_addr[1:0], w_word);
      end
    end
  end

  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model, expected-response queues, decoupled monitors.
// Two instances: LATENCY=3 for the directed/random/reset/hold traffic, LATENCY=1 for back-to-back loads.
// Responses are compared on the falling edge; inputs change on the falling edge or just after the rising edge.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 3;
  localparam int LAT1  = 1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;
  localparam logic       ST   = 1'b0;
  localparam logic       LD   = 1'b1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;
  logic        req1_valid, req1_ready, req1_wen, resp1_valid, resp1_ready, resp1_err;
  logic [31:0] req1_addr, req1_wdata, resp1_rdata;
  logic [1:0]  req1_size;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   hold   = 0;
  bit   rr_rand = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   seen0 = 0;
  bit   seen1 = 0;
  int   last_hs0 = 0;
  logic [7:0] mem_m [4*DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_size(req_size), .i_req_wen(req_wen), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req1_valid), .o_req_ready(req1_ready),
    .i_req_addr(req1_addr), .i_req_size(req1_size), .i_req_wen(req1_wen), .i_req_wdata(req1_wdata),
    .o_resp_valid(resp1_valid), .i_resp_ready(resp1_ready),
    .o_resp_rdata(resp1_rdata), .o_resp_err(resp1_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the access rules: bytes little-endian, errors leave memory untouched
  task automatic model_access(input logic [31:0] a, input logic [1:0] s, input logic w,
                              input logic [31:0] d, output logic [31:0] rd, output logic e);
    int unsigned nb;
    nb = (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
    rd = 32'h0;
    e  = (s == SZ_X) || ((a % nb) != 0) || (a >= 4*DEPTH);
    if (!e) begin
      for (int i = 0; i < int'(nb); i++) begin
        if (w == ST) mem_m[a + i] = d[8*i +: 8];
        else         rd = rd | (32'(mem_m[a + i]) << (8*i));
      end
    end
  endtask

  // Present one request on the LATENCY=3 port; called just after a falling edge, returns just after one
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic w, input logic [31:0] d,
                       input bit track, output int acc);
    exp_t e;
    int   n;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    if (track) model_access(a, s, w, d, e.rdata, e.err);
    req_addr = a; req_size = s; req_wen = w; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      acc = -1;
    end else begin
      acc   = cyc;
      e.acc = cyc;
      if (track) q0.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Requester-side ready for the LATENCY=3 port, changed just after the rising edge
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = hold ? 1'b0 : (rr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor for the LATENCY=3 port
  always @(negedge clk) begin
    if (rst_n) begin
      if (q0.size() == 0) begin
        chk("dut0_valid_without_request", 32'(resp_valid), 32'd0);
        seen0 = 0;
      end else if (resp_valid) begin
        if (!seen0) begin
          chk("dut0_latency", 32'(cyc), 32'(q0[0].acc + LAT0));
          seen0 = 1;
        end
        chk("dut0_rdata", resp_rdata, q0[0].rdata);
        chk("dut0_err", 32'(resp_err), 32'(q0[0].err));
        chk("dut0_req_ready_during_resp", 32'(req_ready), 32'd0);
        if (resp_ready) begin
          void'(q0.pop_front());
          seen0    = 0;
          last_hs0 = cyc;
        end
      end
    end
  end

  // Monitor for the LATENCY=1 port (resp_ready tied high)
  always @(negedge clk) begin
    if (rst_n) begin
      if (q1.size() == 0) begin
        chk("dut1_valid_without_request", 32'(resp1_valid), 32'd0);
        seen1 = 0;
      end else if (resp1_valid) begin
        if (!seen1) begin
          chk("dut1_latency", 32'(cyc), 32'(q1[0].acc + LAT1));
          seen1 = 1;
        end
        chk("dut1_rdata", resp1_rdata, q1[0].rdata);
        chk("dut1_err", 32'(resp1_err), 32'(q1[0].err));
        if (resp1_ready) begin
          void'(q1.pop_front());
          seen1 = 0;
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int          acc;
    int          acc_b;
    int          prev;
    int          n;
    logic [31:0] a;
    logic [31:0] d1 [8];
    exp_t        e1;

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_wen = LD; req_wdata = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_size = '0; req1_wen = LD; req1_wdata = '0;
    resp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", 32'(resp_err), 32'd0);
    chk("reset1_req_ready", 32'(req1_ready), 32'd1);
    chk("reset1_resp_valid", 32'(resp1_valid), 32'd0);

    // Give the test window 0x00..0x3F known contents; word @0x20 starts at zero
    for (int i = 0; i < 16; i++) issue(32'(4*i), SZ_W, ST, (i == 8) ? 32'h0 : $urandom, 1, acc);

    // Word store/load, then byte merge and lane selection
    issue(32'h10, SZ_W, ST, 32'hDEADBEEF, 1, acc);
    issue(32'h10, SZ_W, LD, 32'h0, 1, acc);
    issue(32'h11, SZ_B, ST, 32'hFFFF_FFA5, 1, acc);
    issue(32'h10, SZ_W, LD, 32'h0, 1, acc);
    issue(32'h12, SZ_H, LD, 32'h0, 1, acc);
    issue(32'h13, SZ_B, LD, 32'h0, 1, acc);

    // Error cases, then confirm the word at 0x10 was not disturbed
    issue(32'h11, SZ_H, LD, 32'h0, 1, acc);
    issue(32'h12, SZ_W, ST, 32'hCAFEF00D, 1, acc);
    issue(32'h00, SZ_X, LD, 32'h0, 1, acc);
    issue(32'(4*DEPTH), SZ_W, LD, 32'h0, 1, acc);
    issue(32'h10, SZ_W, LD, 32'h0, 1, acc);

    // Response stall with the next request already waiting on the bus
    wait_drain();
    hold = 1'b1;
    issue(32'h10, SZ_W, LD, 32'h0, 1, acc);
    fork
      issue(32'h14, SZ_W, LD, 32'h0, 1, acc_b);
      begin
        repeat (7) @(negedge clk);
        hold = 1'b0;
      end
    join
    chk("hold_next_accept_cycle", 32'(acc_b), 32'(last_hs0 + 1));
    wait_drain();

    // Reset one cycle into the wait: the store must never reach the array
    issue(32'h20, SZ_W, ST, 32'h12345678, 0, acc);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midwait_reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("midwait_reset_rdata", resp_rdata, 32'd0);
    chk("midwait_reset_err", 32'(resp_err), 32'd0);
    chk("midwait_reset_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    issue(32'h20, SZ_W, LD, 32'h0, 1, acc);

    // Randomised traffic with random response backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      n = $urandom_range(0, 19);
      if (n == 0)      a = 32'hFFFF_FFFC;
      else if (n == 1) a = 32'(4*DEPTH) + $urandom_range(0, 255);
      else             a = 32'($urandom_range(0, 63));
      issue(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1, acc);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rr_rand = 1'b0;
    wait_drain();

    // LATENCY=1 instance: request valid held high, 8 word stores then 8 loads back to back
    req1_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        d1[i] = $urandom;
        req1_addr = 32'(32'h40 + 4*i); req1_size = SZ_W; req1_wen = ST; req1_wdata = d1[i];
        e1.rdata = 32'h0;
      end else begin
        req1_addr = 32'(32'h40 + 4*(i-8)); req1_size = SZ_W; req1_wen = LD; req1_wdata = $urandom;
        e1.rdata = d1[i-8];
      end
      e1.err = 1'b0;
      n = 0;
      while (!req1_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!req1_ready) begin
        chk("dut1_accept_timeout", 32'(req1_ready), 32'd1);
      end else begin
        if (i > 0) chk("dut1_b2b_interval", 32'(cyc - prev), 32'(LAT1 + 1));
        prev   = cyc;
        e1.acc = cyc;
        q1.push_back(e1);
      end
      @(negedge clk);
    end
    req1_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory interface: accepts one byte/halfword/word load or store request at a time, performs it against an internal little-endian word array after a programmable latency, and returns a response through a valid/ready handshake. It sits on the other end of the CPU's data port and replaces the zero-latency data memory when the core moves to a multi-cycle or stalling datapath. Size encoding and the neg-asserted write enable match the existing memory convention.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_wen  in  1  write enable, neg-asserted (0 = store, 1 = load).
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  32  load data, zero-extended, right-justified; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range, or illegal size.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready capture addr/size/wen/wdata, load counter with LATENCY-1; go to RESP if LATENCY==1, else WAIT.
- WAIT: req_ready=0; counter decrements each cycle; when counter==1, perform the access at that edge and go to RESP.
- Access (single edge): error check first; if error, no array write, rdata=0, err=1. Else store merges only addressed bytes into word addr[31:2] (other bytes unchanged); load reads word, selects lane by addr[1:0], zero-extends.
- Error conditions: size==11; size==01 with addr[0]=1; size==10 with addr[1:0]!=0; addr >= 4*DEPTH_WORDS.
- RESP: resp_valid=1, resp_rdata/resp_err stable until resp_valid&&resp_ready; then IDLE. req_ready=0 in RESP (no back-to-back overlap).
- Array contents are not reset.

## Timing
- Reset (rst=0 at a rising edge): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 from the first cycle after reset released. Reset has priority over all other events.
- Reset during WAIT: request abandoned; a store not yet performed is never written. Reset during RESP: response dropped; an already-performed store remains in the array.
- Request accepted at edge N: access performed and resp_valid high from edge N+LATENCY.
- resp_ready held low: response held indefinitely, no further requests accepted.
- Response handshake at edge M: req_ready=1 after edge M; earliest next acceptance at edge M+1. Throughput: one request per LATENCY+1 cycles with resp_ready tied high.
- req_ready is a function of state only (no combinational path from req_valid/resp_ready).
- Read-after-write: a load issued after a store's response observes the stored data.

## Structure
- Shared package cpu_mem_pkg: SIZE_BYTE/SIZE_HWORD/SIZE_WORD codes, WEN active level, FSM state encoding.
- Sub-module dmem_array: DEPTH_WORDS x 32 storage with per-byte write strobes (4 bits), synchronous write, asynchronous read. Top level owns FSM, counter, error check, lane steering and strobe generation.

## Test plan
- After reset, store word 0xDEADBEEF @0x10 (wen=0, size=10), load word @0x10 -> resp_valid exactly LATENCY cycles after acceptance, rdata=0xDEADBEEF, err=0.
- Store byte 0xA5 @0x11, then load word @0x10 -> 0xDEADA5EF; load halfword @0x12 -> 0x0000DEAD; load byte @0x13 -> 0x000000DE.
- Load halfword @0x11, store word @0x12, size=11 @0x0, load @4*DEPTH_WORDS -> each err=1, rdata=0, word @0x10 unchanged.
- Hold resp_ready=0 for 5 cycles with req_valid=1 and new request on bus -> resp_valid/rdata stable, req_ready=0, second request accepted only the cycle after the response handshake.
- Issue store 0x12345678 @0x20 (old 0), assert rst=0 one cycle into WAIT (LATENCY=3) -> outputs reset values next cycle, subsequent load @0x20 returns 0x00000000.
- LATENCY=1 build, resp_ready tied high, 8 back-to-back loads -> one response every 2 cycles, data correct.
